// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit 7-segment scan driver.
// Segment vectors are active-high, bit order {a,b,c,d,e,f,g}.
package seg7_pkg;

    typedef enum logic [1:0] {
        BLANK_UNI = 2'd0,
        SHOW_UNI  = 2'd1,
        BLANK_DEC = 2'd2,
        SHOW_DEC  = 2'd3
    } scan_state_t;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b0000000;
    localparam seg_t SEG_0   = 7'b1111110;
    localparam seg_t SEG_1   = 7'b0110000;
    localparam seg_t SEG_2   = 7'b1101101;
    localparam seg_t SEG_3   = 7'b1111001;
    localparam seg_t SEG_4   = 7'b0110011;
    localparam seg_t SEG_5   = 7'b1011011;
    localparam seg_t SEG_6   = 7'b1011111;
    localparam seg_t SEG_7   = 7'b1110000;
    localparam seg_t SEG_8   = 7'b1111111;
    localparam seg_t SEG_9   = 7'b1111011;

endpackage

// File: rtl/seg7_digit_rom.sv
// Combinational decimal digit to segment pattern lookup.
// Codes 10..15 never occur in normal use and map to all segments off.
module seg7_digit_rom
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output seg_t       pattern
);

    // Plain lookup table; unused codes fall through to a dark digit.
    always_comb begin
        pattern = SEG_OFF;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver for a 0..15 binary value.
// Scan order: blank, units, blank, tens; the shown value only changes at
// the end of the tens slot so a frame never mixes two samples.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: keep the tens digit dark
// when the value is below ten (timing and frame_done are unaffected).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int   REFRESH_DIV    = 50000,
    parameter int   BLANK_CYCLES   = 1000,
    parameter logic SEG_ACTIVE_LOW = 1'b0,
    parameter logic EN_ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bin_in,
    input  logic       load,
    output logic [6:0] seg,
    output logic       pin_uni,
    output logic       pin_dec,
    output logic       frame_done
);

    localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       pending, shown, shown_nxt;
    logic             last_cycle, boundary;
    logic             tens_nxt, dec_phase, dec_blank, seg_load;
    logic [3:0]       units_nxt, rom_digit;
    seg_t             rom_seg, seg_q;
    logic             uni_q, dec_q;

    // Slot timing, next state and the frame-boundary value update.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 1'b1;
        last_cycle = (state == BLANK_UNI || state == BLANK_DEC) ? (cnt == BLANK_LAST)
                                                                : (cnt == SHOW_LAST);
        if (last_cycle) begin
            cnt_nxt = '0;
            case (state)
                BLANK_UNI: state_nxt = SHOW_UNI;
                SHOW_UNI:  state_nxt = BLANK_DEC;
                BLANK_DEC: state_nxt = SHOW_DEC;
                default:   state_nxt = BLANK_UNI;
            endcase
        end
        boundary  = (state == SHOW_DEC) && last_cycle;
        shown_nxt = shown;
        if (boundary) begin
            shown_nxt = load ? bin_in : pending;
        end
    end

    // Select the digit for the slot being entered and decide when seg may move.
    always_comb begin
        tens_nxt  = (shown_nxt >= 4'd10);
        units_nxt = shown_nxt - (tens_nxt ? 4'd10 : 4'd0);
        dec_phase = (state_nxt == BLANK_DEC) || (state_nxt == SHOW_DEC);
        rom_digit = dec_phase ? {3'b000, tens_nxt} : units_nxt;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        dec_blank = dec_phase && !tens_nxt;
`else
        dec_blank = 1'b0;
`endif
        seg_load  = (state_nxt == BLANK_UNI) || (state_nxt == BLANK_DEC) ||
                    (state == BLANK_UNI) || (state == BLANK_DEC);
    end

    seg7_digit_rom u_rom (
        .digit   (rom_digit),
        .pattern (rom_seg)
    );

    // Scan state and slot counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BLANK_UNI;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Value capture and registered panel outputs, aligned with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 4'd0;
            shown   <= 4'd0;
            seg_q   <= SEG_OFF;
            uni_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            shown <= shown_nxt;
            if (load) begin
                pending <= bin_in;
            end
            if (seg_load) begin
                seg_q <= dec_blank ? SEG_OFF : rom_seg;
            end
            uni_q <= (state_nxt == SHOW_UNI);
            dec_q <= (state_nxt == SHOW_DEC) && !dec_blank;
        end
    end

    assign seg        = seg_q ^ {7{SEG_ACTIVE_LOW}};
    assign pin_uni    = uni_q ^ EN_ACTIVE_LOW;
    assign pin_dec    = dec_q ^ EN_ACTIVE_LOW;
    assign frame_done = boundary && rst_n;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a 12-cycle frame (REFRESH_DIV=4, BLANK_CYCLES=2).
// Runs an active-high and an active-low instance side by side on the same stimulus.
module tb_seg7_scan_driver;

    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int FRAME = 2 * (RD + BC);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] bin_in;
    logic       load;
    logic [6:0] seg, seg_inv;
    logic       pin_uni, pin_dec, frame_done;
    logic       pin_uni_inv, pin_dec_inv, frame_done_inv;

    typedef struct {
        int frame;
        int val;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  pos = 0;
    int  frame = 0;
    int  cur_val = 0;
    bit  after_reset = 1'b0;
    bit  started = 1'b0;
    logic [6:0] pat_tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1111011};

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC),
                       .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
        .seg(seg), .pin_uni(pin_uni), .pin_dec(pin_dec), .frame_done(frame_done)
    );

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC),
                       .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
        .seg(seg_inv), .pin_uni(pin_uni_inv), .pin_dec(pin_dec_inv),
        .frame_done(frame_done_inv)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s frame=%0d pos=%0d: got %b expected %b",
                     tag, frame, pos, obs, expv);
        end
    endtask

    // Frame position tracker; pops the scoreboard when a new frame begins.
    always @(posedge clk) begin
        if (!rst_n) begin
            pos = 0;
            frame = 0;
            cur_val = 0;
            after_reset = 1'b1;
            started = 1'b1;
            sb_q.delete();
        end else begin
            after_reset = 1'b0;
            if (pos == FRAME - 1) begin
                pos = 0;
                frame++;
                if (sb_q.size() > 0 && sb_q[0].frame == frame) begin
                    cur_val = sb_q[0].val;
                    void'(sb_q.pop_front());
                end
            end else begin
                pos++;
            end
        end
    end

    // Compare both instances against the expected panel image each cycle.
    always @(negedge clk) begin
        logic [6:0] u_pat, t_pat, e_seg;
        logic       blank_dec, e_uni, e_dec, e_fd;
        if (started && rst_n) begin
            u_pat = pat_tab[cur_val % 10];
            t_pat = pat_tab[cur_val / 10];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            blank_dec = (cur_val < 10);
`else
            blank_dec = 1'b0;
`endif
            if (blank_dec) t_pat = 7'b0000000;
            if (pos == 0 && after_reset) e_seg = 7'b0000000;
            else if (pos < 6)            e_seg = u_pat;
            else                         e_seg = t_pat;
            e_uni = (pos >= 2 && pos <= 5);
            e_dec = (pos >= 8) && !blank_dec;
            e_fd  = (pos == FRAME - 1);
            checkOutput("seg", seg, e_seg);
            checkOutput("pin_uni", {6'b0, pin_uni}, {6'b0, e_uni});
            checkOutput("pin_dec", {6'b0, pin_dec}, {6'b0, e_dec});
            checkOutput("frame_done", {6'b0, frame_done}, {6'b0, e_fd});
            checkOutput("seg_inv", seg_inv, ~e_seg);
            checkOutput("pin_uni_inv", {6'b0, pin_uni_inv}, {6'b0, ~e_uni});
            checkOutput("pin_dec_inv", {6'b0, pin_dec_inv}, {6'b0, ~e_dec});
            checkOutput("frame_done_inv", {6'b0, frame_done_inv}, {6'b0, e_fd});
        end
    end

    // Wait (bounded) until the cycle at frame f, position p has started.
    task automatic waitFor(input int f, input int p);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (frame == f && pos == p) hit = 1'b1;
        end
        if (!hit) checkOutput("wait_timeout", 7'd0, 7'd1);
    endtask

    // Pulse load during cycle (f,p); the value is due in the following frame.
    task automatic applyStimulus(input logic [3:0] v, input int f, input int p);
        sb_t e;
        waitFor(f, p);
        load   = 1'b1;
        bin_in = v;
        e.frame = frame + 1;
        e.val   = int'(v);
        if (sb_q.size() > 0 && sb_q[$].frame == e.frame) void'(sb_q.pop_back());
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        load   = 1'b0;
        bin_in = 4'd0;
    endtask

    // One-cycle reset pulse during cycle (f,p).
    task automatic applyReset(input int f, input int p);
        waitFor(f, p);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        bin_in = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] reset released, frame length %0d cycles", FRAME);
        applyStimulus(4'd13, 0, 3);
        applyStimulus(4'd7,  2, 2);
        applyStimulus(4'd12, 2, 7);
        applyStimulus(4'd9,  3, FRAME - 1);
        applyStimulus(4'd5,  4, 4);
        applyStimulus(4'd8,  5, 0);
        applyReset(7, 9);
        applyStimulus(4'd10, 0, 5);
        waitFor(2, FRAME - 1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
